// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle between the ALU command sequencer and its environment.
// slave = the sequencer; master = upstream producer, ALU and result consumer.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_chain;

  logic       alu_on;
  logic [2:0] alu_in_selector;
  logic [7:0] alu_num1;
  logic [7:0] alu_num2;
  logic [6:0] alu_out_selector;
  logic [7:0] alu_result;
  logic [1:0] alu_state;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_error;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
    input  alu_result, alu_state, res_ready,
    output cmd_ready, alu_on, alu_in_selector, alu_num1, alu_num2,
    output alu_out_selector, res_valid, res_data, res_error
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
    output alu_result, alu_state, res_ready,
    input  cmd_ready, alu_on, alu_in_selector, alu_num1, alu_num2,
    input  alu_out_selector, res_valid, res_data, res_error
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 8-bit ALU: FIFO-buffers requests, issues them one
// at a time, captures the result after the ALU's one-cycle latency.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input logic                 clk,
  input logic                 rst,
  alu_cmd_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int unsigned    ENTRY_W    = 20;
  localparam logic [2:0]     OP_ILLEGAL = 3'd7;
  localparam logic [PTR_W:0] FULL_CNT   = (PTR_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W:0]     r_count;

  logic [1:0] r_state;
  logic       r_alu_on;
  logic [7:0] r_num1;
  logic [7:0] r_num2;
  logic [6:0] r_out_sel;
  logic [7:0] r_last;
  logic [7:0] r_res_data;
  logic       r_res_error;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic [2:0]         w_head_op;
  logic [7:0]         w_head_a;
  logic [7:0]         w_head_b;
  logic               w_head_chain;
  logic [6:0]         w_head_sel;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.cmd_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rptr];
  assign {w_head_op, w_head_a, w_head_b, w_head_chain} = w_head;

  always_comb begin
    w_head_sel = '0;
    case (w_head_op)
      3'd0:    w_head_sel = 7'b1000000;
      3'd1:    w_head_sel = 7'b0100000;
      3'd2:    w_head_sel = 7'b0001000;
      3'd3:    w_head_sel = 7'b0010000;
      3'd4:    w_head_sel = 7'b0000100;
      3'd5:    w_head_sel = 7'b0000010;
      3'd6:    w_head_sel = 7'b0000001;
      default: w_head_sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_chain};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Operands are latched at pop so they are already stable throughout ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_alu_on    <= 1'b0;
      r_num1      <= '0;
      r_num2      <= '0;
      r_out_sel   <= '0;
      r_last      <= '0;
      r_res_data  <= '0;
      r_res_error <= 1'b0;
    end else begin
      r_alu_on <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_head_op == OP_ILLEGAL) begin
              r_res_data  <= '0;
              r_res_error <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_num1    <= w_head_chain ? r_last : w_head_a;
              r_num2    <= w_head_b;
              r_out_sel <= w_head_sel;
              r_state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          r_res_data  <= bus.alu_result;
          r_last      <= bus.alu_result;
          r_res_error <= (bus.alu_state == 2'b11);
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready        = !w_full;
  assign bus.alu_on           = r_alu_on;
  assign bus.alu_in_selector  = (r_state == S_ISSUE) ? 3'b010 : 3'b001;
  assign bus.alu_num1         = r_num1;
  assign bus.alu_num2         = r_num2;
  assign bus.alu_out_selector = r_out_sel;
  assign bus.res_valid        = (r_state == S_RESP);
  assign bus.res_data         = r_res_data;
  assign bus.res_error        = r_res_error;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU stand-in.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;
  exp_t sb_q[$];

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ALU stand-in: registers operands on load, result combinational from them.
  logic [7:0]  m_a, m_b, m_res;
  logic [15:0] m_prod;
  always @(posedge clk) begin
    if (bus.alu_in_selector == 3'b010) begin
      m_a <= bus.alu_num1;
      m_b <= bus.alu_num2;
    end
  end
  assign m_prod = {8'd0, m_a} * {8'd0, m_b};
  always_comb begin
    m_res = '0;
    case (bus.alu_out_selector)
      7'b1000000: m_res = m_a & m_b;
      7'b0100000: m_res = m_a | m_b;
      7'b0010000: m_res = ~m_a;
      7'b0001000: m_res = m_a ^ m_b;
      7'b0000100: m_res = m_a + m_b;
      7'b0000010: m_res = m_a - m_b;
      7'b0000001: m_res = m_prod[7:0];
      default:    m_res = '0;
    endcase
  end
  assign bus.alu_result = m_res;
  assign bus.alu_state  = (bus.alu_out_selector == 7'b0000001 && m_prod[15:8] != 8'd0)
                          ? 2'b11 : 2'b01;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && bus.res_valid && bus.res_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data=%h err=%b, expected no result",
                 bus.res_data, bus.res_error);
      end else begin
        e = sb_q.pop_front();
        if (bus.res_data !== e.data || bus.res_error !== e.err) begin
          errors++;
          $display("FAIL sb_result: got data=%h err=%b, expected data=%h err=%b",
                   bus.res_data, bus.res_error, e.data, e.err);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic chain, input logic expect_res,
                      input logic [7:0] ed, input logic ee);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_chain = chain;
    while (!bus.cmd_ready && n < 50) begin
      step(1);
      n++;
    end
    check("push_ready", 32'(bus.cmd_ready), 32'd1);
    if (bus.cmd_ready) begin
      @(posedge clk);
      #1;
      if (expect_res) sb_q.push_back({ed, ee});
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (bus.alu_in_selector !== 3'b010 && n < 40) begin
      step(1);
      n++;
    end
    check("issue_seen", 32'(bus.alu_in_selector), 32'(3'b010));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      step(1);
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    step(2);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_chain = 1'b0;
    bus.res_ready = 1'b1;

    #12;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data",  32'(bus.res_data),  32'd0);
    check("rst_res_error", 32'(bus.res_error), 32'd0);
    check("rst_alu_on",    32'(bus.alu_on),    32'd0);
    check("rst_in_sel",    32'(bus.alu_in_selector), 32'(3'b001));
    check("rst_num1",      32'(bus.alu_num1),  32'd0);
    check("rst_num2",      32'(bus.alu_num2),  32'd0);
    check("rst_out_sel",   32'(bus.alu_out_selector), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step(1);
    check("alu_on_after_rst", 32'(bus.alu_on), 32'd1);

    // Single ADD: ISSUE drive and pop-to-valid latency
    push(3'd4, 8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0);
    step(1);
    check("add_issue_out_sel", 32'(bus.alu_out_selector), 32'(7'b0000100));
    check("add_issue_in_sel",  32'(bus.alu_in_selector),  32'(3'b010));
    check("add_issue_num1",    32'(bus.alu_num1), 32'h12);
    check("add_issue_num2",    32'(bus.alu_num2), 32'h34);
    step(1);
    check("add_wait_valid",    32'(bus.res_valid), 32'd0);
    check("add_wait_out_sel",  32'(bus.alu_out_selector), 32'(7'b0000100));
    check("add_wait_in_sel",   32'(bus.alu_in_selector),  32'(3'b001));
    step(1);
    check("add_resp_valid",    32'(bus.res_valid), 32'd1);
    wait_drain();

    // Chain: 5+3 = 8, then 8-2 = 6
    push(3'd4, 8'h05, 8'h03, 1'b0, 1'b1, 8'h08, 1'b0);
    wait_issue();
    check("chain1_num1", 32'(bus.alu_num1), 32'h05);
    push(3'd5, 8'hAA, 8'h02, 1'b1, 1'b1, 8'h06, 1'b0);
    wait_issue();
    check("chain2_num1",    32'(bus.alu_num1), 32'h08);
    check("chain2_out_sel", 32'(bus.alu_out_selector), 32'(7'b0000010));
    wait_drain();

    // MULT overflow flags error; following XOR is clean
    push(3'd6, 8'h20, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1);
    push(3'd2, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'hCC, 1'b0);
    wait_drain();

    // Illegal op: no ISSUE, response one cycle after pop
    push(3'd7, 8'h11, 8'h22, 1'b0, 1'b1, 8'h00, 1'b1);
    step(1);
    check("illegal_in_sel", 32'(bus.alu_in_selector), 32'(3'b001));
    check("illegal_valid",  32'(bus.res_valid), 32'd1);
    wait_drain();
    // last_result still 0xCC from the XOR
    push(3'd4, 8'h00, 8'h01, 1'b1, 1'b1, 8'hCD, 1'b0);
    wait_drain();

    // Backpressure: one in flight plus four queued fills the FIFO
    bus.res_ready = 1'b0;
    push(3'd0, 8'hFF, 8'h0F, 1'b0, 1'b1, 8'h0F, 1'b0);
    push(3'd1, 8'hF0, 8'h0F, 1'b0, 1'b1, 8'hFF, 1'b0);
    push(3'd3, 8'h55, 8'h00, 1'b0, 1'b1, 8'hAA, 1'b0);
    push(3'd5, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0);
    push(3'd6, 8'h03, 8'h05, 1'b0, 1'b1, 8'h0F, 1'b0);
    check("bp_full_ready", 32'(bus.cmd_ready), 32'd0);
    step(4);
    check("bp_hold_valid", 32'(bus.res_valid), 32'd1);
    check("bp_hold_data",  32'(bus.res_data),  32'h0F);
    check("bp_hold_ready", 32'(bus.cmd_ready), 32'd0);
    bus.res_ready = 1'b1;
    wait_drain();

    // Reset while a command is in WAIT with two more queued
    push(3'd4, 8'h01, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
    push(3'd4, 8'h02, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0);
    push(3'd4, 8'h03, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0);
    check("pre_rst_valid", 32'(bus.res_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_valid",   32'(bus.res_valid), 32'd0);
    check("mid_rst_data",    32'(bus.res_data),  32'd0);
    check("mid_rst_in_sel",  32'(bus.alu_in_selector), 32'(3'b001));
    check("mid_rst_out_sel", 32'(bus.alu_out_selector), 32'd0);
    check("mid_rst_alu_on",  32'(bus.alu_on), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1);
    check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    step(8);
    check("post_rst_no_valid", 32'(bus.res_valid), 32'd0);
    push(3'd4, 8'h99, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0);
    wait_issue();
    check("post_rst_chain_num1", 32'(bus.alu_num1), 32'h00);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, expected completion");
    $fatal(1, "watchdog timeout");
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream command front-end for the 8-bit ALU datapath.
- Accepts operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Issues one request at a time onto the ALU's operand, input-select and output-select lines, captures the ALU result after its fixed one-cycle latency, and returns it over a valid/ready result handshake with an error flag.
- Supports chaining, where the previous result becomes operand A, without relying on the ALU's internal accumulator recirculation.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- PTR_W, 2, log2(DEPTH), pointer width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_op  in  3  0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SUB, 6 MULT, 7 illegal
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_chain  in  1  use last result as operand A, ignore cmd_a
- alu_on  out  1  ALU enable
- alu_in_selector  out  3  [2] persist, [1] load, [0] reset
- alu_num1  out  8  operand A to ALU
- alu_num2  out  8  operand B to ALU
- alu_out_selector  out  7  one-hot: [6] AND, [5] OR, [4] NOT, [3] XOR, [2] ADD, [1] SUB, [0] MULT
- alu_result  in  8  ALU output value (combinational from the ALU's registered operands)
- alu_state  in  2  ALU FSM state; 2'b11 = run_error (overflow)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  8  captured result
- res_error  out  1  overflow or illegal opcode

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied (pointers and count = 0); FSM returns to IDLE.
  - last_result = 0; res_valid = 0, res_data = 0, res_error = 0.
  - alu_on = 0, alu_in_selector = 3'b001, alu_num1 = alu_num2 = 0, alu_out_selector = 0.
- FIFO:
  - Push when cmd_valid && cmd_ready; pop on the IDLE→ISSUE transition. The stored entry is {op, a, b, chain}.
  - Simultaneous push and pop: count unchanged.
  - When full, cmd_ready = 0 regardless of a same-cycle pop (no push-through).
  - Pointers wrap modulo DEPTH.
- alu_on is 1 in every cycle after reset deasserts.
- alu_in_selector is 3'b010 (load) only in ISSUE and 3'b001 (reset) in all other states. The persist encoding 3'b100 is never driven.
- FSM states are IDLE, ISSUE, WAIT and RESP:
  - IDLE: if the FIFO is non-empty, pop the head into the command register.
    - Legal op: go to ISSUE.
    - op = 7: load res_data = 0, res_error = 1, go to RESP (no ALU issue).
  - ISSUE (1 cycle): drive alu_num1 = chain ? last_result : a, alu_num2 = b, alu_out_selector = decoded one-hot, alu_in_selector = load. The ALU registers the operands at the end of this cycle. Go to WAIT.
  - WAIT (1 cycle): alu_out_selector is held and alu_result is valid.
    - At the end of the cycle: res_data ← alu_result, last_result ← alu_result, res_error ← (alu_state == 2'b11). Go to RESP.
    - last_result is updated even on error.
  - RESP: res_valid = 1; res_data and res_error are held stable.
    - On res_ready = 1: res_valid deasserts on the next edge, then IDLE.
    - res_ready asserted before res_valid has no effect.
- Latency and throughput:
  - Pop to res_valid is 3 cycles: IDLE, ISSUE, WAIT, then RESP.
  - With res_ready tied high, throughput is 1 result per 4 cycles.
- Chaining:
  - cmd_chain with no prior result uses last_result = 0.
  - Illegal-op commands do not update last_result.
- Arithmetic is performed by the ALU: 8-bit wrap. MULT overflow is reported only through alu_state.
- Reset mid-operation: the in-flight command and all queued commands are discarded and no result is produced.

Test Plan:
- Single ADD, a=8'h12, b=8'h34, res_ready=1:
  - ISSUE drives alu_out_selector = 7'b0000100 and alu_in_selector = 3'b010.
  - res_valid asserts 3 cycles after pop with res_data = 8'h46, res_error = 0.
- Chain: ADD a=5, b=3, then SUB chain=1, b=2:
  - The second issue drives alu_num1 = 8'h08.
  - Results are 8'h08, then 8'h06.
- MULT a=8'h20, b=8'h10 with alu_state = 2'b11 during WAIT:
  - res_error = 1 and res_data = alu_result.
  - The next command gets res_error = 0.
- Illegal op = 7:
  - No ISSUE cycle (alu_in_selector stays 3'b001).
  - res_valid asserts with res_data = 0, res_error = 1, 1 cycle after pop.
- Backpressure:
  - Hold res_ready = 0 and push 5 commands (DEPTH = 4).
  - The FIFO fills and cmd_ready drops to 0 after 4 entries are queued.
  - Release res_ready: all results return in order.
- Reset during WAIT with 2 queued:
  - rst=0 immediately clears res_valid and cmd_ready is 1 after release.
  - No stale results appear; last_result = 0 (a chain then uses A = 0).
